// File: rtl/rift2_wb_arb.sv
// Round-robin arbiter sharing the Rift2 target port between Wishbone and the LA debug requester.
// Latency: 3 cycles minimum (request -> ack); WB address miss 2 cycles. One access outstanding; WAIT aborts after TIMEOUT.
module rift2_wb_arb #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFF0_0000,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] DEAD_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_adr_i,
    input  logic [31:0] dbg_dat_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_dat_o,
    output logic        tgt_req_o,
    output logic        tgt_we_o,
    output logic [3:0]  tgt_sel_o,
    output logic [31:0] tgt_adr_o,
    output logic [31:0] tgt_wdat_o,
    input  logic        tgt_ack_i,
    input  logic [31:0] tgt_rdat_i,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       GNT_WB  = 1'b0;
    localparam logic       GNT_DBG = 1'b1;
    localparam logic [7:0] TMO     = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        gnt_q, gnt_d;
    logic        abort_q, abort_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tgt_req_q, tgt_req_d;
    logic        tgt_we_q, tgt_we_d;
    logic [3:0]  tgt_sel_q, tgt_sel_d;
    logic [31:0] tgt_adr_q, tgt_adr_d;
    logic [31:0] tgt_wdat_q, tgt_wdat_d;
    logic        wbs_ack_q, wbs_ack_d;
    logic [31:0] wbs_dat_q, wbs_dat_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic [31:0] dbg_dat_q, dbg_dat_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        wb_vld;
    logic        wb_hit;
    logic        pick_wb;
    logic [31:0] rsp_dat;

    assign wb_vld  = wbs_cyc_i & wbs_stb_i;
    assign wb_hit  = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    // WB wins when alone or when debug had the previous grant.
    assign pick_wb = wb_vld & (~dbg_req_i | (last_gnt_q == GNT_DBG));

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        abort_d    = abort_q;
        cnt_d      = cnt_q;
        tgt_req_d  = tgt_req_q;
        tgt_we_d   = tgt_we_q;
        tgt_sel_d  = tgt_sel_q;
        tgt_adr_d  = tgt_adr_q;
        tgt_wdat_d = tgt_wdat_q;
        wbs_ack_d  = 1'b0;
        wbs_dat_d  = wbs_dat_q;
        dbg_ack_d  = 1'b0;
        dbg_dat_d  = dbg_dat_q;
        err_cnt_d  = err_cnt_q;
        rsp_dat    = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (pick_wb && !wb_hit) begin
                    // Out-of-window WB access: answer locally, arbitration history untouched.
                    state_d   = S_RESP;
                    wbs_ack_d = 1'b1;
                    wbs_dat_d = 32'h0;
                end else if (pick_wb || dbg_req_i) begin
                    state_d    = S_WAIT;
                    gnt_d      = pick_wb ? GNT_WB : GNT_DBG;
                    last_gnt_d = gnt_d;
                    abort_d    = 1'b0;
                    cnt_d      = 8'd0;
                    tgt_req_d  = 1'b1;
                    if (pick_wb) begin
                        tgt_we_d   = wbs_we_i;
                        tgt_sel_d  = wbs_sel_i;
                        tgt_adr_d  = wbs_adr_i;
                        tgt_wdat_d = wbs_dat_i;
                    end else begin
                        tgt_we_d   = dbg_we_i;
                        tgt_sel_d  = 4'hF;
                        tgt_adr_d  = dbg_adr_i;
                        tgt_wdat_d = dbg_dat_i;
                    end
                end
            end

            S_WAIT: begin
                if (gnt_q == GNT_WB && !wbs_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (tgt_ack_i || cnt_q == TMO) begin
                    state_d   = S_RESP;
                    tgt_req_d = 1'b0;
                    if (tgt_we_q) begin
                        rsp_dat = 32'h0;
                    end else if (tgt_ack_i) begin
                        rsp_dat = tgt_rdat_i;
                    end else begin
                        rsp_dat = DEAD_DATA;
                    end
                    // An ack landing on the expiry cycle is a normal completion.
                    if (!tgt_ack_i && err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (gnt_q == GNT_WB) begin
                        if (!abort_q && wbs_cyc_i) begin
                            wbs_ack_d = 1'b1;
                            wbs_dat_d = rsp_dat;
                        end
                    end else begin
                        dbg_ack_d = 1'b1;
                        dbg_dat_d = rsp_dat;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= GNT_DBG;
            gnt_q      <= GNT_WB;
            abort_q    <= 1'b0;
            cnt_q      <= 8'd0;
            tgt_req_q  <= 1'b0;
            tgt_we_q   <= 1'b0;
            tgt_sel_q  <= 4'h0;
            tgt_adr_q  <= 32'h0;
            tgt_wdat_q <= 32'h0;
            wbs_ack_q  <= 1'b0;
            wbs_dat_q  <= 32'h0;
            dbg_ack_q  <= 1'b0;
            dbg_dat_q  <= 32'h0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            abort_q    <= abort_d;
            cnt_q      <= cnt_d;
            tgt_req_q  <= tgt_req_d;
            tgt_we_q   <= tgt_we_d;
            tgt_sel_q  <= tgt_sel_d;
            tgt_adr_q  <= tgt_adr_d;
            tgt_wdat_q <= tgt_wdat_d;
            wbs_ack_q  <= wbs_ack_d;
            wbs_dat_q  <= wbs_dat_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_dat_q  <= dbg_dat_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign wbs_ack_o  = wbs_ack_q;
    assign wbs_dat_o  = wbs_dat_q;
    assign dbg_ack_o  = dbg_ack_q;
    assign dbg_dat_o  = dbg_dat_q;
    assign tgt_req_o  = tgt_req_q;
    assign tgt_we_o   = tgt_we_q;
    assign tgt_sel_o  = tgt_sel_q;
    assign tgt_adr_o  = tgt_adr_q;
    assign tgt_wdat_o = tgt_wdat_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_rift2_wb_arb.sv
// Directed bench for rift2_wb_arb: arbitration order, window miss, timeout, saturation and reset abandonment.
module tb_rift2_wb_arb;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_adr_i, dbg_dat_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_dat_o;
    logic        tgt_req_o, tgt_we_o;
    logic [3:0]  tgt_sel_o;
    logic [31:0] tgt_adr_o, tgt_wdat_o;
    logic        tgt_ack_i;
    logic [31:0] tgt_rdat_i;
    logic [7:0]  err_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    rift2_wb_arb #(
        .BASE_ADDR (32'h3000_0000),
        .ADDR_MASK (32'hFFF0_0000),
        .TIMEOUT   (8),
        .DEAD_DATA (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .dbg_req_i  (dbg_req_i),
        .dbg_we_i   (dbg_we_i),
        .dbg_adr_i  (dbg_adr_i),
        .dbg_dat_i  (dbg_dat_i),
        .dbg_ack_o  (dbg_ack_o),
        .dbg_dat_o  (dbg_dat_o),
        .tgt_req_o  (tgt_req_o),
        .tgt_we_o   (tgt_we_o),
        .tgt_sel_o  (tgt_sel_o),
        .tgt_adr_o  (tgt_adr_o),
        .tgt_wdat_o (tgt_wdat_o),
        .tgt_ack_i  (tgt_ack_i),
        .tgt_rdat_i (tgt_rdat_i),
        .err_cnt_o  (err_cnt_o)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        int acks;
        int cyc;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_adr_i = 32'h0; dbg_dat_i = 32'h0;
        tgt_ack_i = 1'b0; tgt_rdat_i = 32'h0;

        repeat (3) tick();
        chk("rst_wbs_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_wbs_dat", wbs_dat_o, 32'h0);
        chk("rst_dbg_ack", 32'(dbg_ack_o), 32'h0);
        chk("rst_dbg_dat", dbg_dat_o, 32'h0);
        chk("rst_tgt_req", 32'(tgt_req_o), 32'h0);
        chk("rst_tgt_adr", tgt_adr_o, 32'h0);
        chk("rst_tgt_sel", 32'(tgt_sel_o), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'h0);
        wb_rst_n = 1'b1;
        tick();

        // First tie after reset: WB write first, then DBG read
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0100; wbs_dat_i = 32'hAAAA_0001;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_adr_i = 32'hDB00_0000;
        tick();
        chk("tie1_req", 32'(tgt_req_o), 32'h1);
        chk("tie1_adr_wb", tgt_adr_o, 32'h3000_0100);
        chk("tie1_we", 32'(tgt_we_o), 32'h1);
        chk("tie1_wdat", tgt_wdat_o, 32'hAAAA_0001);
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'hFFFF_FFFF;
        tick();
        chk("tie1_wbs_ack", 32'(wbs_ack_o), 32'h1);
        chk("tie1_wbs_dat_wr0", wbs_dat_o, 32'h0);
        chk("tie1_dbg_ack0", 32'(dbg_ack_o), 32'h0);
        chk("tie1_req_drop", 32'(tgt_req_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; tgt_ack_i = 1'b0;
        tick();
        chk("tie1_wbs_ack_1cyc", 32'(wbs_ack_o), 32'h0);
        tick();
        chk("tie1_dbg_req", 32'(tgt_req_o), 32'h1);
        chk("tie1_adr_dbg", tgt_adr_o, 32'hDB00_0000);
        chk("tie1_sel_dbg", 32'(tgt_sel_o), 32'hF);
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'hCAFE_0001;
        tick();
        chk("tie1_dbg_ack", 32'(dbg_ack_o), 32'h1);
        chk("tie1_dbg_dat", dbg_dat_o, 32'hCAFE_0001);
        chk("tie1_wbs_ack0", 32'(wbs_ack_o), 32'h0);
        dbg_req_i = 1'b0; tgt_ack_i = 1'b0; tgt_rdat_i = 32'h0;
        tick();
        chk("tie1_dbg_ack_1cyc", 32'(dbg_ack_o), 32'h0);
        chk("tie1_dbg_dat_hold", dbg_dat_o, 32'hCAFE_0001);

        // WB read in window, target acks 2 cycles after request
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'h3;
        wbs_adr_i = 32'h3000_0010;
        tick();
        chk("rd_req", 32'(tgt_req_o), 32'h1);
        chk("rd_sel", 32'(tgt_sel_o), 32'h3);
        chk("rd_adr", tgt_adr_o, 32'h3000_0010);
        tick();
        tick();
        chk("rd_no_early_ack", 32'(wbs_ack_o), 32'h0);
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'h1234_5678;
        tick();
        chk("rd_wbs_ack", 32'(wbs_ack_o), 32'h1);
        chk("rd_wbs_dat", wbs_dat_o, 32'h1234_5678);
        chk("rd_req_drop", 32'(tgt_req_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; tgt_ack_i = 1'b0; tgt_rdat_i = 32'h0;
        tick();
        chk("rd_ack_1cyc", 32'(wbs_ack_o), 32'h0);
        chk("rd_dat_hold", wbs_dat_o, 32'h1234_5678);

        // Second tie: WB had the last grant, so DBG write goes first
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0200;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_adr_i = 32'hDB00_0004; dbg_dat_i = 32'h5555_0000;
        tick();
        chk("tie2_adr_dbg", tgt_adr_o, 32'hDB00_0004);
        chk("tie2_we", 32'(tgt_we_o), 32'h1);
        chk("tie2_wdat", tgt_wdat_o, 32'h5555_0000);
        tick();
        chk("tie2_wait_req", 32'(tgt_req_o), 32'h1);
        chk("tie2_wait_adr", tgt_adr_o, 32'hDB00_0004);
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'h1111_1111;
        tick();
        chk("tie2_dbg_ack", 32'(dbg_ack_o), 32'h1);
        chk("tie2_dbg_dat_wr0", dbg_dat_o, 32'h0);
        chk("tie2_wbs_ack0", 32'(wbs_ack_o), 32'h0);
        dbg_req_i = 1'b0; tgt_ack_i = 1'b0;
        tick();
        tick();
        chk("tie2_wb_req", 32'(tgt_req_o), 32'h1);
        chk("tie2_adr_wb", tgt_adr_o, 32'h3000_0200);
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'h0BAD_F00D;
        tick();
        chk("tie2_wbs_ack", 32'(wbs_ack_o), 32'h1);
        chk("tie2_wbs_dat", wbs_dat_o, 32'h0BAD_F00D);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; tgt_ack_i = 1'b0;
        tick();

        // WB miss outside the window
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h2000_0000;
        tick();
        chk("miss_ack", 32'(wbs_ack_o), 32'h1);
        chk("miss_dat", wbs_dat_o, 32'h0);
        chk("miss_no_req", 32'(tgt_req_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        chk("miss_ack_1cyc", 32'(wbs_ack_o), 32'h0);
        chk("miss_no_req2", 32'(tgt_req_o), 32'h0);

        // Timeout: ack 9 cycles after tgt_req rises
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_adr_i = 32'hDB00_0008;
        tick();
        chk("tmo_req", 32'(tgt_req_o), 32'h1);
        repeat (8) tick();
        chk("tmo_no_early_ack", 32'(dbg_ack_o), 32'h0);
        chk("tmo_req_held", 32'(tgt_req_o), 32'h1);
        tick();
        chk("tmo_dbg_ack", 32'(dbg_ack_o), 32'h1);
        chk("tmo_dbg_dat", dbg_dat_o, 32'hDEAD_BEEF);
        chk("tmo_err_cnt", 32'(err_cnt_o), 32'h1);
        chk("tmo_req_drop", 32'(tgt_req_o), 32'h0);
        dbg_req_i = 1'b0;
        tick();

        // Ack on the expiry cycle wins
        dbg_req_i = 1'b1; dbg_adr_i = 32'hDB00_000C;
        tick();
        repeat (8) tick();
        chk("exp_no_early_ack", 32'(dbg_ack_o), 32'h0);
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'hA5A5_A5A5;
        tick();
        chk("exp_dbg_ack", 32'(dbg_ack_o), 32'h1);
        chk("exp_dbg_dat", dbg_dat_o, 32'hA5A5_A5A5);
        chk("exp_err_cnt", 32'(err_cnt_o), 32'h1);
        dbg_req_i = 1'b0; tgt_ack_i = 1'b0;
        tick();

        // WB abort: cyc drops in WAIT, access completes silently
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0300;
        tick();
        chk("abt_req", 32'(tgt_req_o), 32'h1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        tgt_ack_i = 1'b1; tgt_rdat_i = 32'h7777_7777;
        tick();
        chk("abt_req_drop", 32'(tgt_req_o), 32'h0);
        chk("abt_no_ack", 32'(wbs_ack_o), 32'h0);
        chk("abt_dat_hold", wbs_dat_o, 32'h0);
        tgt_ack_i = 1'b0;
        tick();
        chk("abt_no_ack2", 32'(wbs_ack_o), 32'h0);

        // Saturation: 299 more timeouts on top of the one already counted
        dbg_req_i = 1'b1; dbg_adr_i = 32'hDB00_0010;
        acks = 0;
        cyc = 0;
        while (acks < 299 && cyc < 6000) begin
            tick();
            cyc++;
            if (dbg_ack_o) acks++;
        end
        dbg_req_i = 1'b0;
        chk("sat_ack_count", 32'(acks), 32'd299);
        chk("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        chk("sat_dbg_dat", dbg_dat_o, 32'hDEAD_BEEF);
        tick();
        tick();

        // Reset in the middle of WAIT
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0400;
        tick();
        chk("rw_req", 32'(tgt_req_o), 32'h1);
        tick();
        #2;
        wb_rst_n = 1'b0;
        #1;
        chk("rw_tgt_req", 32'(tgt_req_o), 32'h0);
        chk("rw_tgt_adr", tgt_adr_o, 32'h0);
        chk("rw_wbs_dat", wbs_dat_o, 32'h0);
        chk("rw_dbg_dat", dbg_dat_o, 32'h0);
        chk("rw_err_cnt", 32'(err_cnt_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; tgt_ack_i = 1'b1;
        tick();
        tgt_ack_i = 1'b0;
        tick();
        wb_rst_n = 1'b1;
        tick();
        tick();
        chk("rw_no_late_ack", 32'(wbs_ack_o), 32'h0);
        chk("rw_no_req", 32'(tgt_req_o), 32'h0);

        // First tie after the reset goes to WB again
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0500;
        dbg_req_i = 1'b1; dbg_adr_i = 32'hDB00_0020;
        tick();
        chk("rw_tie_adr_wb", tgt_adr_o, 32'h3000_0500);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; dbg_req_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rift2_wb_arb.md
# rift2_wb_arb

Two-port arbiter that shares the single Rift2 internal configuration/memory target port between the Caravel management Wishbone slave interface and the logic-analyzer debug requester. It sits inside `rift2Wrap`, between the `wbs_*` pins and the core's target port. Accesses are serialised with round-robin priority and at most one outstanding transaction. A timeout guarantees that neither requester can hang the management bus.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: Wishbone address window base.
- `ADDR_MASK`, default 32'hFFF0_0000: a Wishbone access hits when `(wbs_adr_i & ADDR_MASK) == BASE_ADDR`.
- `TIMEOUT`, default 255: WAIT cycles allowed before the block aborts the access (range 1..255).
- `DEAD_DATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic slave controls.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid while `wbs_ack_o` is high.
- `dbg_req_i`  in  1  level request; held until `dbg_ack_o`.
- `dbg_we_i`  in  1  debug write enable.
- `dbg_adr_i`, `dbg_dat_i`  in  32 each  debug address and write data.
- `dbg_ack_o`  out  1  one-cycle acknowledge.
- `dbg_dat_o`  out  32  debug read data.
- `tgt_req_o`, `tgt_we_o`  out  1 each  target request and write enable.
- `tgt_sel_o`  out  4  target byte lanes.
- `tgt_adr_o`, `tgt_wdat_o`  out  32 each  target address and write data.
- `tgt_ack_i`  in  1  target completion.
- `tgt_rdat_i`  in  32  target read data.
- `err_cnt_o`  out  8  count of timeouts; saturates at 255.

## Operation
- State machine: IDLE → WAIT → RESP → IDLE.
- **WB valid:** `wbs_cyc_i & wbs_stb_i`.
- **DBG valid:** `dbg_req_i`.
- **IDLE arbitration:**
  - Only one requester valid: grant it.
  - Both valid: grant the requester not recorded in `last_gnt`.
  - `last_gnt` reset value is DBG, so WB wins the first tie.
  - `last_gnt` updates on every grant.
- **WB miss (address outside the window):**
  - No target access and no grant.
  - Go directly to RESP with `wbs_dat_o` = 0.
  - `last_gnt` is unchanged.
- **Grant:**
  - Register address, write data and write enable from the granted requester.
  - Debug `sel` is 4'hF; WB `sel` is `wbs_sel_i`.
  - Assert `tgt_req_o`, enter WAIT, clear the timeout counter.
- **WAIT:**
  - `tgt_req_o` and all `tgt_*` fields are held stable.
  - The counter increments each cycle.
  - On `tgt_ack_i`: capture `tgt_rdat_i`, drop `tgt_req_o`, go to RESP.
- **Timeout:**
  - Counter reaches `TIMEOUT` with no ack: drop `tgt_req_o`, read data = `DEAD_DATA`, `err_cnt_o` += 1 (saturating), go to RESP.
  - `tgt_ack_i` in the same cycle as expiry: the ack wins and no error is counted.
- **RESP:**
  - Pulse the granted requester's `*_ack_o` for exactly one cycle with the captured data.
  - The other requester's ack stays 0. Return to IDLE.
- **WB abort (`wbs_cyc_i` drops while WB is granted):**
  - The target access still completes.
  - `wbs_ack_o` is suppressed in RESP.
- Read-data outputs hold their last value outside ack cycles.
- Writes return data 0.

## Timing
- **Reset:** state IDLE, `last_gnt` = DBG, counter 0, and every output 0 (`wbs_ack_o`, `wbs_dat_o`, `dbg_ack_o`, `dbg_dat_o`, all `tgt_*`, `err_cnt_o`).
- **Reset mid-transaction:** abandons it immediately; no ack is issued afterwards.
- **Request path:** request sampled in IDLE at edge N → `tgt_req_o` high from N+1.
- **Completion path:** `tgt_ack_i` sampled at edge M → `tgt_req_o` low and `*_ack_o` high from M+1 for one cycle → IDLE from M+2.
  - The next `tgt_req_o` is earliest M+3.
  - Minimum access latency is 3 cycles, request to ack.
- **Address miss:** ack one cycle after sampling (latency 2).
- **Timeout:** `*_ack_o` rises `TIMEOUT`+1 cycles after `tgt_req_o` rose.
- **Re-acceptance:** a requester still asserting in the cycle after its ack (RESP+1) is treated as a new request. Masters must deassert `stb`/`req` on seeing ack.
- **Constraint on `tgt_ack_i`:** it is only meaningful in WAIT and is ignored elsewhere.

## Test plan
- **WB read in window:** `wbs_adr_i`=32'h3000_0010, target acks 2 cycles after `tgt_req_o` with 32'h1234_5678 → `wbs_ack_o` one cycle, `wbs_dat_o`=32'h1234_5678, `tgt_sel_o`=`wbs_sel_i`.
- **Simultaneous requests:** WB and DBG requests start in the same cycle after reset → WB served first, DBG second (`tgt_adr_o` sequence WB then DBG). Repeat the tie → DBG first this time.
- **WB miss:** `wbs_adr_i`=32'h2000_0000 → `wbs_ack_o` 2 cycles after `stb`, `wbs_dat_o`=0, `tgt_req_o` never asserts.
- **Timeout:** `TIMEOUT`=8, target never acks → `dbg_ack_o` 9 cycles after `tgt_req_o` rise, `dbg_dat_o`=32'hDEAD_BEEF, `err_cnt_o`=1. Force 300 timeouts → `err_cnt_o` holds at 255.
- **Ack on expiry:** `tgt_ack_i` in the exact expiry cycle with data 32'hA5A5_A5A5 → normal completion, that data returned, `err_cnt_o` unchanged.
- **Reset mid-WAIT:** assert `wb_rst_n`=0 mid-WAIT → all outputs 0 asynchronously, no later ack. After release, the first tie goes to WB.
